pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Holds the architectural program counter and drives instruction fetch for the RISC-V core. Each cycle it selects the next PC, either sequential PC+4 or a taken branch/jump target. It issues a valid/ready request to instruction memory, captures the returned word, and presents it to decode with its PC. It absorbs decode back-pressure, stalls and redirects, and flags misaligned branch targets.

Parameters:
RESET_VECTOR, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, value of INSTR_OUT after reset (addi x0,x0,0).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
STALL  input  1  hazard stall from pipeline control; blocks PC advance
BRANCH_TAKEN  input  1  single-cycle redirect strobe from execute
BRANCH_TARGET  input  32  redirect address, sampled when BRANCH_TAKEN=1
IMEM_REQ_VALID  output  1  fetch request valid
IMEM_REQ_READY  input  1  memory accepts request
IMEM_ADDR  output  32  fetch address, word aligned
IMEM_RSP_VALID  input  1  response word valid, at least 1 cycle after acceptance
IMEM_RSP_DATA  input  32  fetched instruction word
INSTR_VALID  output  1  INSTR_OUT/INSTR_PC valid for decode
INSTR_READY  input  1  decode consumes instruction
INSTR_OUT  output  32  fetched instruction
INSTR_PC  output  32  PC of INSTR_OUT
MISALIGN_EXC  output  1  sticky: redirect target not 4-byte aligned

Behaviour:
- Reset (rst_n=0 at edge): PC=RESET_VECTOR, req_addr=RESET_VECTOR, kill=0, state=IDLE. Outputs: IMEM_REQ_VALID=0, IMEM_ADDR=RESET_VECTOR, INSTR_VALID=0, INSTR_OUT=NOP_INSTR, INSTR_PC=0, MISALIGN_EXC=0. Reset overrides every other input.
- States and transitions:
  - IDLE: go to REQ next cycle; req_addr<=PC.
  - REQ: IMEM_REQ_VALID=1, IMEM_ADDR=req_addr. IMEM_ADDR is held stable while VALID=1 and READY=0. On VALID&READY, go to WAIT.
  - WAIT: wait for IMEM_RSP_VALID.
    - If kill=1: discard the response, clear kill, req_addr<=PC, go to REQ.
    - Else: INSTR_OUT<=DATA, INSTR_PC<=req_addr, INSTR_VALID<=1, go to HOLD.
  - HOLD: INSTR_VALID=1, outputs held. On INSTR_READY=1 and STALL=0: PC<=PC+4, req_addr<=PC+4, INSTR_VALID<=0, go to REQ.
  - TRAP: all valids 0, MISALIGN_EXC=1; exit only by reset.
- Minimum loop latency: REQ accepted (cycle 0), response at cycle 1, INSTR_VALID at cycle 2, consume at cycle 2, next request at cycle 3.
- IMEM_RSP_VALID outside WAIT is ignored. This covers a stale response after a mid-operation reset.
- Redirect (BRANCH_TAKEN=1, any state except TRAP):
  - Target[1:0]!=0: MISALIGN_EXC<=1, INSTR_VALID<=0, IMEM_REQ_VALID<=0, go to TRAP. PC is unchanged.
  - Aligned target: PC<=target.
    - IDLE: req_addr<=target.
    - REQ: an unaccepted request cannot change address, so the request completes as is with kill<=1. If it is accepted the same cycle, go to WAIT with kill=1.
    - WAIT: kill<=1, unless the response arrives the same cycle. In that case discard it and go to REQ with req_addr=target.
    - HOLD: INSTR_VALID<=0, req_addr<=target, go to REQ.
- Priority: reset > BRANCH_TAKEN > STALL > INSTR_READY. A branch in the same cycle as INSTR_READY drops the held instruction and takes the target.
- STALL affects only HOLD. Fetch still proceeds up to HOLD while stalled.
- PC arithmetic: unsigned 32-bit, modulo 2^32. 32'hFFFFFFFC+4 = 32'h00000000, with no flag.

Decomposition:
- Shared package: state encoding (IDLE, REQ, WAIT, HOLD, TRAP), NOP_INSTR, default RESET_VECTOR.
- One sub-module: the team's existing PC+4 adder Program_Counter_Next, instantiated for the sequential increment.
- Next-PC mux, FSM and kill flag stay inline.

Test Plan:
- Reset then free run, memory READY=1, 1-cycle response, INSTR_READY=1 -> IMEM_ADDR sequence 0x0, 0x4, 0x8; INSTR_PC matches; INSTR_VALID high every 3rd cycle.
- Hold IMEM_REQ_READY=0 for 4 cycles at addr 0x8 -> IMEM_ADDR stable at 0x8, REQ_VALID stays 1, no INSTR_VALID.
- In HOLD with INSTR_PC=0x4, assert STALL for 3 cycles with INSTR_READY=1 -> INSTR_OUT/INSTR_PC frozen. Release -> next request to 0x8.
- BRANCH_TAKEN with target 0x100 while in WAIT for 0xC -> response for 0xC discarded, next IMEM_ADDR=0x100, next INSTR_PC=0x100.
- BRANCH_TAKEN with target 0x102 -> MISALIGN_EXC=1 next cycle and held, INSTR_VALID=0, no requests until rst_n=0. After reset: MISALIGN_EXC=0, IMEM_ADDR=RESET_VECTOR.
- Force PC to 0xFFFFFFFC via redirect, consume -> next IMEM_ADDR=0x00000000. Also: rst_n low during WAIT with a late IMEM_RSP_VALID -> response ignored, INSTR_VALID stays 0.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding
// and default reset/NOP constants.
package pc_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    TRAP
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: pipeline control, instruction-memory handshake and the
// decode-facing instruction handshake.
interface pc_fetch_ctrl_if;

  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        IMEM_REQ_VALID;
  logic        IMEM_REQ_READY;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RSP_VALID;
  logic [31:0] IMEM_RSP_DATA;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] INSTR_OUT;
  logic [31:0] INSTR_PC;
  logic        MISALIGN_EXC;

  modport master (
    input  STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_REQ_READY,
           IMEM_RSP_VALID, IMEM_RSP_DATA, INSTR_READY,
    output IMEM_REQ_VALID, IMEM_ADDR, INSTR_VALID, INSTR_OUT, INSTR_PC,
           MISALIGN_EXC
  );

  modport slave (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_REQ_READY,
           IMEM_RSP_VALID, IMEM_RSP_DATA, INSTR_READY,
    input  IMEM_REQ_VALID, IMEM_ADDR, INSTR_VALID, INSTR_OUT, INSTR_PC,
           MISALIGN_EXC
  );

endinterface

// File: rtl/Program_Counter_Next.sv
// Sequential next-PC adder: PC+4, wrapping modulo 2^32 without a carry flag.
module Program_Counter_Next (
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o
);

  assign pc_next_o = pc_i + 32'd4;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction fetch FSM: issues one outstanding memory
// request at a time, holds the returned word for decode, and handles redirects.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_ctrl_if.master fetch
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         kill_q, kill_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_out_q, instr_out_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  pc_plus4;

  Program_Counter_Next u_pc_next (
    .pc_i      (pc_q),
    .pc_next_o (pc_plus4)
  );

  assign fetch.IMEM_REQ_VALID = (state_q == REQ);
  assign fetch.IMEM_ADDR      = req_addr_q;
  assign fetch.INSTR_VALID    = instr_valid_q;
  assign fetch.INSTR_OUT      = instr_out_q;
  assign fetch.INSTR_PC       = instr_pc_q;
  assign fetch.MISALIGN_EXC   = misalign_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    kill_d        = kill_q;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    misalign_d    = misalign_q;

    if (fetch.BRANCH_TAKEN && state_q != TRAP) begin
      if (!is_word_aligned(fetch.BRANCH_TARGET)) begin
        misalign_d    = 1'b1;
        instr_valid_d = 1'b0;
        state_d       = TRAP;
      end else begin
        pc_d = fetch.BRANCH_TARGET;
        case (state_q)
          IDLE: begin
            req_addr_d = fetch.BRANCH_TARGET;
            state_d    = REQ;
          end
          REQ: begin
            // The address of a presented request is frozen; let it finish and
            // throw its response away.
            kill_d = 1'b1;
            if (fetch.IMEM_REQ_READY) state_d = WAIT;
          end
          WAIT: begin
            if (fetch.IMEM_RSP_VALID) begin
              kill_d     = 1'b0;
              req_addr_d = fetch.BRANCH_TARGET;
              state_d    = REQ;
            end else begin
              kill_d = 1'b1;
            end
          end
          HOLD: begin
            instr_valid_d = 1'b0;
            req_addr_d    = fetch.BRANCH_TARGET;
            state_d       = REQ;
          end
          default: state_d = IDLE;
        endcase
      end
    end else begin
      case (state_q)
        IDLE: begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
        REQ: begin
          if (fetch.IMEM_REQ_READY) state_d = WAIT;
        end
        WAIT: begin
          if (fetch.IMEM_RSP_VALID) begin
            if (kill_q) begin
              kill_d     = 1'b0;
              req_addr_d = pc_q;
              state_d    = REQ;
            end else begin
              instr_out_d   = fetch.IMEM_RSP_DATA;
              instr_pc_d    = req_addr_q;
              instr_valid_d = 1'b1;
              state_d       = HOLD;
            end
          end
        end
        HOLD: begin
          if (fetch.INSTR_READY && !fetch.STALL) begin
            pc_d          = pc_plus4;
            req_addr_d    = pc_plus4;
            instr_valid_d = 1'b0;
            state_d       = REQ;
          end
        end
        TRAP:    state_d = TRAP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      req_addr_q    <= RESET_VECTOR;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= NOP_INSTR;
      instr_pc_q    <= 32'h0000_0000;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      kill_q        <= kill_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a per-cycle vector table for the main
// fetch loop plus hand sequences for trap, PC wraparound and reset in WAIT.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;
  localparam logic [31:0] D0   = 32'h0010_0093;
  localparam logic [31:0] D4   = 32'h0020_0113;
  localparam logic [31:0] D8   = 32'h0030_0193;
  localparam logic [31:0] DC   = 32'h0040_0213;
  localparam logic [31:0] D100 = 32'h0050_0293;
  localparam logic [31:0] DF   = 32'h0060_0313;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_ready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_instr_valid;
    logic [31:0] exp_instr_out;
    logic [31:0] exp_instr_pc;
    logic        exp_misalign;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if fetch_bus ();

  pc_fetch_ctrl #(
    .RESET_VECTOR (32'h0000_0000),
    .NOP_INSTR    (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fetch (fetch_bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic rd, input logic rv, input logic [31:0] d, input logic ir);
    rst_n                   = r;
    fetch_bus.STALL         = s;
    fetch_bus.BRANCH_TAKEN  = b;
    fetch_bus.BRANCH_TARGET = t;
    fetch_bus.IMEM_REQ_READY = rd;
    fetch_bus.IMEM_RSP_VALID = rv;
    fetch_bus.IMEM_RSP_DATA  = d;
    fetch_bus.INSTR_READY    = ir;
  endtask

  task automatic check_outs(input string tag, input logic erv, input logic [31:0] ea,
                            input logic eiv, input logic [31:0] eo, input logic [31:0] ep,
                            input logic em);
    check({tag, ".req_valid"},   {31'd0, fetch_bus.IMEM_REQ_VALID}, {31'd0, erv});
    check({tag, ".imem_addr"},   fetch_bus.IMEM_ADDR, ea);
    check({tag, ".instr_valid"}, {31'd0, fetch_bus.INSTR_VALID}, {31'd0, eiv});
    check({tag, ".instr_out"},   fetch_bus.INSTR_OUT, eo);
    check({tag, ".instr_pc"},    fetch_bus.INSTR_PC, ep);
    check({tag, ".misalign"},    {31'd0, fetch_bus.MISALIGN_EXC}, {31'd0, em});
  endtask

  function automatic vec_t mk(
    input logic r, input logic s, input logic b, input logic [31:0] t, input logic rd,
    input logic rv, input logic [31:0] d, input logic ir, input logic erv,
    input logic [31:0] ea, input logic eiv, input logic [31:0] eo, input logic [31:0] ep,
    input logic em);
    vec_t v;
    v.rst_n = r; v.stall = s; v.br = b; v.tgt = t; v.req_ready = rd;
    v.rsp_valid = rv; v.rsp_data = d; v.instr_ready = ir;
    v.exp_req_valid = erv; v.exp_addr = ea; v.exp_instr_valid = eiv;
    v.exp_instr_out = eo; v.exp_instr_pc = ep; v.exp_misalign = em;
    return v;
  endfunction

  initial begin
    // Columns: rst stall br tgt rdy rsp_v rsp_data ir | req_v addr i_v i_out i_pc mis
    vecs.push_back(mk(1,0,0,0,1,0,0,1,           0,32'h0,  0,NOP, 32'h0,  0)); // IDLE
    vecs.push_back(mk(1,0,0,0,1,1,BAD,1,         1,32'h0,  0,NOP, 32'h0,  0)); // REQ 0, stray rsp
    vecs.push_back(mk(1,0,0,0,1,1,D0,1,          0,32'h0,  0,NOP, 32'h0,  0)); // WAIT 0
    vecs.push_back(mk(1,0,0,0,1,0,0,1,           0,32'h0,  1,D0,  32'h0,  0)); // HOLD 0
    vecs.push_back(mk(1,0,0,0,1,0,0,1,           1,32'h4,  0,D0,  32'h0,  0)); // REQ 4
    vecs.push_back(mk(1,0,0,0,1,1,D4,1,          0,32'h4,  0,D0,  32'h0,  0)); // WAIT 4
    vecs.push_back(mk(1,1,0,0,1,0,0,1,           0,32'h4,  1,D4,  32'h4,  0)); // HOLD, stall 1
    vecs.push_back(mk(1,1,0,0,1,0,0,1,           0,32'h4,  1,D4,  32'h4,  0)); // stall 2
    vecs.push_back(mk(1,1,0,0,1,0,0,1,           0,32'h4,  1,D4,  32'h4,  0)); // stall 3
    vecs.push_back(mk(1,0,0,0,1,0,0,1,           0,32'h4,  1,D4,  32'h4,  0)); // release
    vecs.push_back(mk(1,0,0,0,0,0,0,1,           1,32'h8,  0,D4,  32'h4,  0)); // REQ 8, not ready
    vecs.push_back(mk(1,0,0,0,0,0,0,1,           1,32'h8,  0,D4,  32'h4,  0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,           1,32'h8,  0,D4,  32'h4,  0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,           1,32'h8,  0,D4,  32'h4,  0));
    vecs.push_back(mk(1,0,0,0,1,0,0,1,           1,32'h8,  0,D4,  32'h4,  0)); // accepted
    vecs.push_back(mk(1,0,0,0,1,1,D8,1,          0,32'h8,  0,D4,  32'h4,  0)); // WAIT 8
    vecs.push_back(mk(1,0,0,0,1,0,0,1,           0,32'h8,  1,D8,  32'h8,  0)); // HOLD 8
    vecs.push_back(mk(1,0,0,0,1,0,0,1,           1,32'hC,  0,D8,  32'h8,  0)); // REQ C
    vecs.push_back(mk(1,0,1,32'h100,1,0,0,1,     0,32'hC,  0,D8,  32'h8,  0)); // WAIT C, redirect
    vecs.push_back(mk(1,0,0,0,1,1,DC,1,          0,32'hC,  0,D8,  32'h8,  0)); // killed rsp
    vecs.push_back(mk(1,0,0,0,1,0,0,1,           1,32'h100,0,D8,  32'h8,  0)); // REQ 100
    vecs.push_back(mk(1,0,0,0,1,1,D100,1,        0,32'h100,0,D8,  32'h8,  0)); // WAIT 100
    vecs.push_back(mk(1,0,0,0,1,0,0,0,           0,32'h100,1,D100,32'h100,0)); // HOLD, no ready
    vecs.push_back(mk(1,0,1,32'h200,1,0,0,1,     0,32'h100,1,D100,32'h100,0)); // branch beats ready
    vecs.push_back(mk(1,0,0,0,0,0,0,1,           1,32'h200,0,D100,32'h100,0)); // REQ 200 held

    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 0, 32'h0, 0, NOP, 32'h0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].req_ready,
            vecs[i].rsp_valid, vecs[i].rsp_data, vecs[i].instr_ready);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_req_valid, vecs[i].exp_addr,
                 vecs[i].exp_instr_valid, vecs[i].exp_instr_out, vecs[i].exp_instr_pc,
                 vecs[i].exp_misalign);
      @(negedge clk);
    end

    // Misaligned redirect while a request is pending, then sticky trap.
    drive(1, 0, 1, 32'h102, 0, 0, 32'h0, 1);
    check_outs("mis_pre", 1, 32'h200, 0, D100, 32'h100, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, (i == 1), 32'h300, 1, 1, BAD, 1);
      check($sformatf("trap%0d.misalign", i),    {31'd0, fetch_bus.MISALIGN_EXC},   32'd1);
      check($sformatf("trap%0d.req_valid", i),   {31'd0, fetch_bus.IMEM_REQ_VALID}, 32'd0);
      check($sformatf("trap%0d.instr_valid", i), {31'd0, fetch_bus.INSTR_VALID},    32'd0);
      @(negedge clk);
    end
    drive(0, 0, 0, 32'h0, 1, 1, BAD, 1);
    @(negedge clk);
    check_outs("trap_rst", 0, 32'h0, 0, NOP, 32'h0, 0);

    // Redirect to the top word, consume it, sequential PC wraps to zero.
    drive(1, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0, 1);
    check_outs("wrap_idle", 0, 32'h0, 0, NOP, 32'h0, 0);
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 1, 0, 32'h0, 1);
    check_outs("wrap_req", 1, 32'hFFFF_FFFC, 0, NOP, 32'h0, 0);
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 1, 1, DF, 1);
    check_outs("wrap_wait", 0, 32'hFFFF_FFFC, 0, NOP, 32'h0, 0);
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 1, 0, 32'h0, 1);
    check_outs("wrap_hold", 0, 32'hFFFF_FFFC, 1, DF, 32'hFFFF_FFFC, 0);
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 1, 0, 32'h0, 1);
    check_outs("wrap_next", 1, 32'h0, 0, DF, 32'hFFFF_FFFC, 0);
    @(negedge clk);

    // Reset while waiting; the late response must not surface.
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
    check_outs("rstwait_pre", 0, 32'h0, 0, DF, 32'hFFFF_FFFC, 0);
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 0, 1, BAD, 1);
    check_outs("rstwait_idle", 0, 32'h0, 0, NOP, 32'h0, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 32'h0, 0, 1, BAD, 1);
      check_outs($sformatf("rstwait_req%0d", i), 1, 32'h0, 0, NOP, 32'h0, 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
